// File: rtl/ddr_app_bridge_pkg.sv
// ddr_app_bridge_pkg: widths, MIG command codes and FSM encodings
// shared by the CPU-to-MIG bridge and its interfaces.
package ddr_app_bridge_pkg;

  localparam int APP_ADDR_W     = 27;
  localparam int APP_DATA_W     = 128;
  localparam int APP_MASK_W     = APP_DATA_W / 8;
  localparam int MEM_BYTES_LOG2 = 27;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD_CMD  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_ACK     = 3'd4;

endpackage

// File: rtl/ddr_app_bridge_if.sv
// ddr_bus_if: CPU single-word bus; ddr_app_if: MIG UI app_* port.
// master drives the request side, slave answers it.
interface ddr_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

interface ddr_app_if;
  import ddr_app_bridge_pkg::*;

  logic                  init_calib_complete;
  logic [APP_ADDR_W-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [APP_DATA_W-1:0] app_wdf_data;
  logic [APP_MASK_W-1:0] app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [APP_DATA_W-1:0] app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;

  modport master (
    input  init_calib_complete,
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_data, app_wdf_mask,
    output app_wdf_wren, app_wdf_end,
    input  app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid,
    input  app_rd_data_end
  );

  modport slave (
    output init_calib_complete,
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_data, app_wdf_mask,
    input  app_wdf_wren, app_wdf_end,
    output app_wdf_rdy,
    output app_rd_data, app_rd_data_valid,
    output app_rd_data_end
  );
endinterface

// File: rtl/ddr_lane_mux.sv
// ddr_lane_mux: places a 32-bit word into a 128-bit MIG burst
// (replicated data plus byte mask) and picks the word back out.
module ddr_lane_mux
  import ddr_app_bridge_pkg::*;
(
  input  logic [1:0]            lane,
  input  logic [3:0]            sel,
  input  logic [31:0]           wdata,
  input  logic [APP_DATA_W-1:0] rd_data,
  output logic [APP_DATA_W-1:0] wdf_data,
  output logic [APP_MASK_W-1:0] wdf_mask,
  output logic [31:0]           rd_word
);

  always_comb begin
    wdf_data = {4{wdata}};
    wdf_mask = '1;
    rd_word  = rd_data[31:0];
    for (int i = 0; i < 4; i++) begin
      if (lane == i[1:0]) begin
        // mask is active-high "do not write"
        wdf_mask[4*i +: 4] = ~sel;
        rd_word = rd_data[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/ddr_app_bridge.sv
// ddr_app_bridge: one-outstanding CPU word requests to MIG UI commands.
// FSM, split write handshake flags and the read-data register.
module ddr_app_bridge
  import ddr_app_bridge_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ddr_bus_if.slave  bus,
  ddr_app_if.master app
);

  state_t                state;
  logic [1:0]            lane_q;
  logic [1:0]            lane;
  logic                  cmd_done;
  logic                  dat_done;
  logic                  start;
  logic [APP_DATA_W-1:0] pk_data;
  logic [APP_MASK_W-1:0] pk_mask;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  // live bus lane while idle, captured lane afterwards
  assign lane  = (state == ST_IDLE) ? bus.bus_addr[3:2] : lane_q;
  assign start = (state == ST_IDLE) && bus.bus_req
               && app.init_calib_complete;

  assign bus.bus_ack     = (state == ST_ACK);
  assign app.app_wdf_end = app.app_wdf_wren;
  assign unused_ok = ^{bus.bus_addr[31:MEM_BYTES_LOG2],
                       bus.bus_addr[1:0]};

  ddr_lane_mux u_mux (
    .lane     (lane),
    .sel      (bus.bus_sel),
    .wdata    (bus.bus_wdata),
    .rd_data  (app.app_rd_data),
    .wdf_data (pk_data),
    .wdf_mask (pk_mask),
    .rd_word  (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      lane_q           <= '0;
      cmd_done         <= 1'b0;
      dat_done         <= 1'b0;
      app.app_en       <= 1'b0;
      app.app_wdf_wren <= 1'b0;
      app.app_cmd      <= APP_CMD_RD;
      app.app_addr     <= '0;
      app.app_wdf_data <= '0;
      app.app_wdf_mask <= '1;
      bus.bus_rdata    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            lane_q       <= bus.bus_addr[3:2];
            app.app_addr <= {1'b0,
                             bus.bus_addr[MEM_BYTES_LOG2-1:4],
                             3'b000};
            app.app_en   <= 1'b1;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            if (bus.bus_we) begin
              app.app_cmd      <= APP_CMD_WR;
              app.app_wdf_wren <= 1'b1;
              app.app_wdf_data <= pk_data;
              app.app_wdf_mask <= pk_mask;
              state            <= ST_WR;
            end else begin
              app.app_cmd <= APP_CMD_RD;
              state       <= ST_RD_CMD;
            end
          end
        end
        ST_WR: begin
          // command and data channels retire independently
          if (app.app_en && app.app_rdy) begin
            app.app_en <= 1'b0;
            cmd_done   <= 1'b1;
          end
          if (app.app_wdf_wren && app.app_wdf_rdy) begin
            app.app_wdf_wren <= 1'b0;
            dat_done         <= 1'b1;
          end
          if (cmd_done && dat_done) state <= ST_ACK;
        end
        ST_RD_CMD: begin
          if (app.app_rdy) begin
            app.app_en <= 1'b0;
            state      <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (app.app_rd_data_valid) begin
            bus.bus_rdata <= rd_word;
            state         <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_rd_end: assert property (@(posedge clk) disable iff (rst)
    app.app_rd_data_valid |-> app.app_rd_data_end);

endmodule

// File: tb/tb_ddr_app_bridge.sv
// tb_ddr_app_bridge: directed and random checks of ddr_app_bridge
// against a MIG line model and a byte-level reference memory.
module tb_ddr_app_bridge;
  import ddr_app_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_bus_if bus_i ();
  ddr_app_if app_i ();

  ddr_app_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i),
    .app (app_i)
  );

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  // MIG model knobs and observations
  logic [127:0] mig_mem [logic [26:0]];
  int   cmd_stall = 0;
  int   dat_stall = 0;
  bit   rnd_rdy   = 0;
  bit   rnd_delay = 0;
  int   rd_delay  = 0;
  int   en_cycles = 0;
  int   wren_cycles = 0;
  int   rd_cnt = -1;
  logic [127:0] rd_line;
  bit   have_cmd, have_dat;
  logic [26:0]  w_addr;
  logic [127:0] w_data;
  logic [15:0]  w_mask;
  logic [26:0]  last_addr;
  logic [2:0]   last_cmd;
  logic [127:0] last_data;
  logic [15:0]  last_mask;

  logic [7:0] ref_mem [logic [26:0]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial forever begin
    @(negedge clk);
    if (bus_i.bus_ack === 1'b1) acks++;
  end

  initial begin
    logic [127:0] line;
    app_i.app_rdy = 1'b1;
    app_i.app_wdf_rdy = 1'b1;
    app_i.app_rd_data_valid = 1'b0;
    app_i.app_rd_data_end = 1'b0;
    app_i.app_rd_data = '0;
    have_cmd = 0;
    have_dat = 0;
    forever begin
      @(negedge clk);
      app_i.app_rd_data_valid = 1'b0;
      app_i.app_rd_data_end = 1'b0;
      if (rd_cnt == 0) begin
        app_i.app_rd_data_valid = 1'b1;
        app_i.app_rd_data_end = 1'b1;
        app_i.app_rd_data = rd_line;
      end
      if (rd_cnt >= 0) rd_cnt--;
      if (rst) begin
        have_cmd = 0;
        have_dat = 0;
      end
      if (app_i.app_en === 1'b1) en_cycles++;
      if (app_i.app_wdf_wren === 1'b1) wren_cycles++;
      if (app_i.app_en === 1'b1 && cmd_stall > 0) begin
        app_i.app_rdy = 1'b0;
        cmd_stall--;
      end else
        app_i.app_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (app_i.app_wdf_wren === 1'b1 && dat_stall > 0) begin
        app_i.app_wdf_rdy = 1'b0;
        dat_stall--;
      end else
        app_i.app_wdf_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rst && app_i.app_en === 1'b1 && app_i.app_rdy) begin
        last_addr = app_i.app_addr;
        last_cmd  = app_i.app_cmd;
        if (app_i.app_cmd == APP_CMD_WR) begin
          have_cmd = 1;
          w_addr = app_i.app_addr;
        end else begin
          rd_line = mig_mem.exists(app_i.app_addr)
                  ? mig_mem[app_i.app_addr] : '0;
          rd_cnt = rnd_delay ? $urandom_range(0, 3) : rd_delay;
        end
      end
      if (!rst && app_i.app_wdf_wren === 1'b1 && app_i.app_wdf_rdy) begin
        have_dat = 1;
        w_data = app_i.app_wdf_data;
        w_mask = app_i.app_wdf_mask;
        last_data = w_data;
        last_mask = w_mask;
      end
      if (have_cmd && have_dat) begin
        line = mig_mem.exists(w_addr) ? mig_mem[w_addr] : '0;
        for (int b = 0; b < 16; b++)
          if (!w_mask[b]) line[8*b +: 8] = w_data[8*b +: 8];
        mig_mem[w_addr] = line;
        have_cmd = 0;
        have_dat = 0;
      end
    end
  end

  task automatic start_req(input bit we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    bus_i.bus_req   = 1'b1;
    bus_i.bus_we    = we;
    bus_i.bus_addr  = a;
    bus_i.bus_sel   = s;
    bus_i.bus_wdata = d;
  endtask

  task automatic wait_ack(output logic [31:0] rd, output int lat,
                          output bit ok);
    ok = 0;
    lat = -1;
    rd = 'x;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_i.bus_ack === 1'b1) begin
        rd = bus_i.bus_rdata;
        lat = n;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    bus_i.bus_req = 1'b0;
  endtask

  task automatic do_op(input bit we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int lat,
                       output bit ok);
    start_req(we, a, s, d);
    wait_ack(rd, lat, ok);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_i.bus_req = 1'b0;
    bus_i.bus_we = 1'b0;
    bus_i.bus_addr = '0;
    bus_i.bus_sel = '0;
    bus_i.bus_wdata = '0;
    app_i.init_calib_complete = 1'b1;
    idle(3);
    @(negedge clk);
    total += 9;
    if (bus_i.bus_ack !== 1'b0) begin
      bad++; $display("FAIL rst_ack: got %b want 0", bus_i.bus_ack);
    end
    if (bus_i.bus_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_rdata: got %h want 0", bus_i.bus_rdata);
    end
    if (app_i.app_en !== 1'b0) begin
      bad++; $display("FAIL rst_en: got %b want 0", app_i.app_en);
    end
    if (app_i.app_wdf_wren !== 1'b0) begin
      bad++; $display("FAIL rst_wren: got %b want 0", app_i.app_wdf_wren);
    end
    if (app_i.app_wdf_end !== 1'b0) begin
      bad++; $display("FAIL rst_end: got %b want 0", app_i.app_wdf_end);
    end
    if (app_i.app_cmd !== 3'b001) begin
      bad++; $display("FAIL rst_cmd: got %b want 001", app_i.app_cmd);
    end
    if (app_i.app_addr !== 27'h0) begin
      bad++; $display("FAIL rst_addr: got %h want 0", app_i.app_addr);
    end
    if (app_i.app_wdf_data !== 128'h0) begin
      bad++; $display("FAIL rst_data: got %h want 0", app_i.app_wdf_data);
    end
    if (app_i.app_wdf_mask !== 16'hFFFF) begin
      bad++; $display("FAIL rst_mask: got %h want ffff", app_i.app_wdf_mask);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_calib_hold;
    int viol = 0;
    int lat;
    bit ok;
    logic [31:0] rd;
    app_i.init_calib_complete = 1'b0;
    start_req(1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (app_i.app_en !== 1'b0 || bus_i.bus_ack !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL calib_stall: got %0d active cycles want 0", viol);
    end
    app_i.init_calib_complete = 1'b1;
    wait_ack(rd, lat, ok);
    total++;
    if (!ok || lat != 3) begin
      bad++; $display("FAIL calib_release: got lat %0d ok %b want 3", lat, ok);
    end
  endtask

  task automatic test_write_lane2;
    int lat;
    bit ok;
    int a0;
    logic [31:0] rd;
    a0 = acks;
    do_op(1'b1, 32'h0000_0128, 4'b0011, 32'hDEAD_BEEF, rd, lat, ok);
    idle(3);
    total += 5;
    if (!ok || lat != 3 || acks != a0 + 1) begin
      bad++; $display("FAIL wr_ack: got lat %0d acks %0d want 3 and 1", lat, acks - a0);
    end
    if (last_addr !== 27'h0000_090) begin
      bad++; $display("FAIL wr_addr: got %h want 0000090", last_addr);
    end
    if (last_cmd !== APP_CMD_WR) begin
      bad++; $display("FAIL wr_cmd: got %b want 000", last_cmd);
    end
    if (last_mask !== 16'hFCFF) begin
      bad++; $display("FAIL wr_mask: got %h want fcff", last_mask);
    end
    if (last_data !== {4{32'hDEAD_BEEF}}) begin
      bad++; $display("FAIL wr_data: got %h want deadbeef x4", last_data);
    end
  endtask

  task automatic test_read_lane1;
    int lat;
    bit ok;
    logic [31:0] rd;
    mig_mem[27'h80] = {32'h1111_1111, 32'h2222_2222,
                       32'hCAFE_F00D, 32'h4444_4444};
    rd_delay = 20;
    do_op(1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, lat, ok);
    total += 2;
    if (!ok || lat != 23) begin
      bad++; $display("FAIL rd_lat: got %0d want 23", lat);
    end
    if (rd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL rd_data: got %h want cafef00d", rd);
    end
    idle(4);
    do_op(1'b1, 32'h0000_0200, 4'hF, 32'h5555_AAAA, rd, lat, ok);
    @(negedge clk);
    total++;
    if (bus_i.bus_rdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL rd_hold: got %h want cafef00d", bus_i.bus_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_split(input int cs, input int ds);
    int lat;
    bit ok;
    int a0;
    logic [31:0] rd;
    int want;
    want = ((cs > ds) ? cs : ds) + 3;
    a0 = acks;
    cmd_stall = cs;
    dat_stall = ds;
    en_cycles = 0;
    wren_cycles = 0;
    do_op(1'b1, 32'h0000_0300, 4'hF, 32'h0BAD_CAFE, rd, lat, ok);
    idle(3);
    total += 3;
    if (en_cycles != cs + 1) begin
      bad++; $display("FAIL split_en: got %0d want %0d", en_cycles, cs + 1);
    end
    if (wren_cycles != ds + 1) begin
      bad++; $display("FAIL split_wren: got %0d want %0d", wren_cycles, ds + 1);
    end
    if (!ok || lat != want || acks != a0 + 1) begin
      bad++; $display("FAIL split_ack: got lat %0d acks %0d want %0d and 1", lat, acks - a0, want);
    end
  endtask

  task automatic test_reset_mid_read;
    int lat;
    bit ok;
    int a0;
    logic [31:0] rd;
    rd_delay = 10;
    a0 = acks;
    start_req(1'b0, 32'h0000_0104, 4'h0, 32'h0);
    idle(5);
    rst = 1'b1;
    bus_i.bus_req = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(20);
    @(negedge clk);
    total += 3;
    if (acks != a0) begin
      bad++; $display("FAIL rstrd_ack: got %0d acks want 0", acks - a0);
    end
    if (bus_i.bus_rdata !== 32'h0) begin
      bad++; $display("FAIL rstrd_rdata: got %h want 0", bus_i.bus_rdata);
    end
    if (app_i.app_en !== 1'b0) begin
      bad++; $display("FAIL rstrd_en: got %b want 0", app_i.app_en);
    end
    @(posedge clk); #1;
    rd_delay = 3;
    do_op(1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, lat, ok);
    total++;
    if (!ok || lat != 6 || rd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL rstrd_next: got %h lat %0d want cafef00d lat 6", rd, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    int a0;
    bit we;
    logic [31:0] a, wd, rd, exp;
    logic [3:0] s;
    logic [26:0] key;
    mig_mem.delete();
    ref_mem.delete();
    rnd_rdy = 1;
    rnd_delay = 1;
    for (int k = 0; k < 6000; k++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom;
      a[26:7] = 20'($urandom_range(0, 7));
      s = 4'($urandom);
      wd = $urandom;
      a0 = acks;
      do_op(we, a, s, wd, rd, lat, ok);
      total++;
      if (!ok || acks != a0 + 1) begin
        bad++; $display("FAIL rand_ack: op %0d got ok %b acks %0d want 1", k, ok, acks - a0);
      end
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          key = {a[26:2], 2'(i)};
          if (s[i]) ref_mem[key] = wd[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          key = {a[26:2], 2'(i)};
          exp[8*i +: 8] = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
        end
        total++;
        if (rd !== exp) begin
          bad++; $display("FAIL rand_rd: op %0d addr %h got %h want %h", k, a, rd, exp);
        end
      end
    end
    rnd_rdy = 0;
    rnd_delay = 0;
    a0 = acks;
    idle(5);
    total++;
    if (acks != a0) begin
      bad++; $display("FAIL rand_tail: got %0d extra acks want 0", acks - a0);
    end
  endtask

  initial begin
    test_reset();
    test_calib_hold();
    test_write_lane2();
    test_read_lane1();
    test_split(2, 5);
    test_split(5, 2);
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
